// File: rtl/bus_master_if.sv
// Bus master interface: turns a one-cycle requester strobe into request/grant/strobe/ready bus cycles.
// Optional BUS_TIMEOUT_EN adds the TIMEOUT parameter and aborts accesses whose slave never answers.
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32
`ifdef BUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              bus_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              bus_req_n_q, bus_req_n_d;
    logic              bus_as_n_q, bus_as_n_d;
    logic              bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
    logic              start;
    logic              done;
    logic              abort;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    // A ready arriving on the limit cycle wins over the abort.
    assign abort   = (state_q == ST_ACCESS) && bus_rdy_ && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign bus_err = bus_err_q;
`else
    assign abort   = 1'b0;
    assign bus_err = 1'b0;
`endif

    assign start = (state_q == ST_IDLE) && !as_ && !flush;
    assign done  = (state_q == ST_ACCESS) && !bus_rdy_;

    always_comb begin
        state_d       = state_q;
        bus_req_n_d   = bus_req_n_q;
        bus_as_n_d    = bus_as_n_q;
        bus_rw_d      = bus_rw_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_buf_d      = rd_buf_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d         = cnt_q;
        bus_err_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bus_addr_d    = addr;
                    bus_rw_d      = rw;
                    bus_wr_data_d = wr_data;
                    bus_req_n_d   = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!bus_grnt_) begin
                    bus_as_n_d = 1'b0;
                    state_d    = ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_ACCESS: begin
                bus_as_n_d = 1'b1;
                if (done) begin
                    rd_buf_d      = bus_rd_data;
                    bus_req_n_d   = 1'b1;
                    bus_addr_d    = '0;
                    bus_wr_data_d = '0;
                    bus_rw_d      = 1'b1;
                    state_d       = stall ? ST_STALL : ST_IDLE;
                end else if (abort) begin
                    rd_buf_d      = '0;
                    bus_req_n_d   = 1'b1;
                    bus_addr_d    = '0;
                    bus_wr_data_d = '0;
                    bus_rw_d      = 1'b1;
                    state_d       = ST_IDLE;
`ifdef BUS_TIMEOUT_EN
                    bus_err_d     = 1'b1;
`endif
                end else begin
`ifdef BUS_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            ST_STALL: begin
                if (!stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bus_req_n_q   <= 1'b1;
            bus_as_n_q    <= 1'b1;
            bus_rw_q      <= 1'b1;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            rd_buf_q      <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q         <= '0;
            bus_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bus_req_n_q   <= bus_req_n_d;
            bus_as_n_q    <= bus_as_n_d;
            bus_rw_q      <= bus_rw_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_buf_q      <= rd_buf_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q         <= cnt_d;
            bus_err_q     <= bus_err_d;
`endif
        end
    end

    // busy and rd_data are combinational so a ready slave returns data with zero latency.
    always_comb begin
        busy    = 1'b0;
        rd_data = '0;
        case (state_q)
            ST_IDLE:   busy = !as_ && !flush;
            ST_REQ:    busy = 1'b1;
            ST_ACCESS: begin
                busy = bus_rdy_ && !abort;
                if (!bus_rdy_) begin
                    rd_data = bus_rd_data;
                end
            end
            ST_STALL:  rd_data = rd_buf_q;
            default:   busy = 1'b0;
        endcase
    end

    assign bus_req_    = bus_req_n_q;
    assign bus_as_     = bus_as_n_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed and random transfers against a read-data scoreboard.
// Handshake: bus_req_ low asks for the bus, bus_grnt_ low grants it, bus_as_ pulses once, bus_rdy_ low ends the access.
module tb_bus_master_if;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_STALL  = 2'd3;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              bus_err;
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;
    logic [1:0]        dbg_state;

    logic [DATA_W-1:0] exp_q[$];
    int n_cmp;
    int n_err;

    bus_master_if #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .flush(flush),
        .addr(addr),
        .as_(as_),
        .rw(rw),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .busy(busy),
        .bus_err(bus_err),
        .bus_req_(bus_req_),
        .bus_grnt_(bus_grnt_),
        .bus_addr(bus_addr),
        .bus_as_(bus_as_),
        .bus_rw(bus_rw),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .bus_rdy_(bus_rdy_),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every completed read is checked against the oldest expected value
    logic [DATA_W-1:0] sb_exp;
    always @(negedge clk) begin
        if (!reset && !bus_rdy_ && !bus_req_ && bus_rw) begin
            check_eq("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                check_eq("sb_rd_data", rd_data, sb_exp);
            end
        end
    end

    // driver: one complete transfer, checking the bus protocol cycle by cycle
    task automatic xfer(input logic [ADDR_W-1:0] a, input logic r, input logic [DATA_W-1:0] wd,
                        input logic [DATA_W-1:0] rdv, input int gdly, input int rdly,
                        input int stc, input bit fl_acc);
        as_ = 1'b0; rw = r; addr = a; wr_data = wd;
        @(negedge clk);
        check_eq("idle_busy", busy, 1);
        check_eq("idle_req", bus_req_, 1);
        tick();
        as_ = 1'b1; rw = ~r; addr = ADDR_W'($urandom()); wr_data = $urandom();
        for (int i = 0; i < gdly; i++) begin
            bus_grnt_ = 1'b1;
            @(negedge clk);
            check_eq("wait_req", bus_req_, 0);
            check_eq("wait_as", bus_as_, 1);
            check_eq("wait_busy", busy, 1);
            check_eq("wait_wdata", bus_wr_data, wd);
            tick();
        end
        bus_grnt_ = 1'b0;
        @(negedge clk);
        check_eq("req_state", dbg_state, S_REQ);
        check_eq("req_as", bus_as_, 1);
        check_eq("req_addr", bus_addr, a);
        check_eq("req_rw", bus_rw, r);
        tick();
        if (fl_acc) flush = 1'b1;
        if (r) exp_q.push_back(rdv);
        for (int k = 0; k <= rdly; k++) begin
            bus_rdy_    = (k == rdly) ? 1'b0 : 1'b1;
            bus_rd_data = (k == rdly) ? rdv : $urandom();
            stall       = (k == rdly) && (stc > 0);
            @(negedge clk);
            check_eq("acc_state", dbg_state, S_ACCESS);
            check_eq("acc_as", bus_as_, (k == 0) ? 0 : 1);
            check_eq("acc_req", bus_req_, 0);
            check_eq("acc_addr", bus_addr, a);
            check_eq("acc_wdata", bus_wr_data, wd);
            check_eq("acc_busy", busy, (k == rdly) ? 0 : 1);
            check_eq("acc_err", bus_err, 0);
            if (k != rdly) check_eq("acc_rd_zero", rd_data, 0);
            if (k == rdly && !r) check_eq("wr_rd_data", rd_data, rdv);
            tick();
        end
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; flush = 1'b0; bus_rd_data = $urandom();
        for (int s = 0; s < stc; s++) begin
            @(negedge clk);
            check_eq("stall_state", dbg_state, S_STALL);
            check_eq("stall_rd_data", rd_data, rdv);
            check_eq("stall_busy", busy, 0);
            check_eq("stall_req", bus_req_, 1);
            tick();
        end
        if (stc > 0) begin
            stall = 1'b0;
            @(negedge clk);
            check_eq("unstall_state", dbg_state, S_STALL);
            check_eq("unstall_rd_data", rd_data, rdv);
            tick();
        end
        @(negedge clk);
        check_eq("post_state", dbg_state, S_IDLE);
        check_eq("post_req", bus_req_, 1);
        check_eq("post_addr", bus_addr, 0);
        check_eq("post_wdata", bus_wr_data, 0);
        check_eq("post_rw", bus_rw, 1);
        check_eq("post_rd_zero", rd_data, 0);
        check_eq("post_err", bus_err, 0);
        tick();
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic timeout_abort(input logic [ADDR_W-1:0] a);
        as_ = 1'b0; rw = 1'b1; addr = a;
        tick();
        as_ = 1'b1; bus_grnt_ = 1'b0;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            check_eq("tmo_state", dbg_state, S_ACCESS);
            check_eq("tmo_busy", busy, (k == TMO) ? 0 : 1);
            check_eq("tmo_err", bus_err, 0);
            tick();
        end
        bus_grnt_ = 1'b1;
        @(negedge clk);
        check_eq("abort_err", bus_err, 1);
        check_eq("abort_req", bus_req_, 1);
        check_eq("abort_as", bus_as_, 1);
        check_eq("abort_addr", bus_addr, 0);
        check_eq("abort_state", dbg_state, S_IDLE);
        check_eq("abort_busy", busy, 0);
        tick();
        @(negedge clk);
        check_eq("abort_err_pulse", bus_err, 0);
        tick();
    endtask
`endif

    initial begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] wd1;
        n_cmp = 0; n_err = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
        addr = '0; wr_data = '0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        tick();
        @(negedge clk);
        check_eq("rst_state", dbg_state, S_IDLE);
        check_eq("rst_req", bus_req_, 1);
        check_eq("rst_as", bus_as_, 1);
        check_eq("rst_rw", bus_rw, 1);
        check_eq("rst_addr", bus_addr, 0);
        check_eq("rst_wdata", bus_wr_data, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", bus_err, 0);
        tick();
        reset = 1'b0;
        tick();

        xfer(30'h100, 1'b1, 32'h0, 32'hDEADBEEF, 0, 1, 0, 1'b0);
        xfer(30'h20, 1'b0, 32'h12345678, 32'h0BADF00D, 5, 2, 0, 1'b0);
        xfer(30'h44, 1'b1, 32'h0, 32'hCAFEF00D, 1, 0, 3, 1'b0);

        // flush in IDLE suppresses the access entirely
        flush = 1'b1; as_ = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", busy, 0);
        tick();
        @(negedge clk);
        check_eq("flush_req", bus_req_, 1);
        check_eq("flush_state", dbg_state, S_IDLE);
        tick();
        flush = 1'b0; as_ = 1'b1;
        tick();

        xfer(30'h3AA, 1'b1, 32'h0, 32'h5A5A0F0F, 2, 3, 0, 1'b1);
        xfer(30'h3FFFFFFF, 1'b1, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 1'b0);
        xfer(30'h0, 1'b0, 32'hA5A5A5A5, 32'h0, 0, 0, 1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            ra  = ADDR_W'($urandom());
            rd1 = $urandom();
            wd1 = $urandom();
            xfer(ra, 1'($urandom_range(0, 1)), wd1, rd1, $urandom_range(0, 4),
                 $urandom_range(0, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

`ifdef BUS_TIMEOUT_EN
        timeout_abort(30'h77);
        xfer(30'h78, 1'b1, 32'h0, 32'h1357ACE0, 0, TMO - 1, 0, 1'b0);
`else
        xfer(30'h79, 1'b1, 32'h0, 32'h2468BDF1, 1, 20, 0, 1'b0);
`endif

        // asynchronous reset in the middle of ACCESS
        as_ = 1'b0; rw = 1'b1; addr = 30'h155;
        tick();
        as_ = 1'b1; bus_grnt_ = 1'b0;
        tick();
        @(negedge clk);
        check_eq("mid_pre_as", bus_as_, 0);
        check_eq("mid_pre_req", bus_req_, 0);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_req", bus_req_, 1);
        check_eq("mid_rst_as", bus_as_, 1);
        check_eq("mid_rst_addr", bus_addr, 0);
        check_eq("mid_rst_rd_data", rd_data, 0);
        check_eq("mid_rst_state", dbg_state, S_IDLE);
        check_eq("mid_rst_busy", busy, 0);
        bus_grnt_ = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        xfer(30'h156, 1'b1, 32'h0, 32'h600DCAFE, 0, 1, 0, 1'b0);

        check_eq("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
